// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the integer MAC datapath.
package mac_pkg;

   localparam int DEF_PROD_W = 32;
   localparam int DEF_ACC_W  = 40;
   localparam int DEF_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla_nbit.sv
// rtl/cla_nbit.sv - n-bit carry-lookahead adder built from 4-bit lookahead groups.
module cla_nbit #(
   parameter int n = 40
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] sum,
   output logic         cout
);

   // Padded to at least n+1 bits so the carry out of bit n-1 appears as sum bit n.
   localparam int NG = (n + 4) / 4;
   localparam int NP = NG * 4;

   logic [NP-1:0] a_p;
   logic [NP-1:0] b_p;
   logic [NP-1:0] g;
   logic [NP-1:0] p;
   logic [NP-1:0] s_p;
   logic          unused_pad;

   always_comb begin
      a_p        = '0;
      b_p        = '0;
      a_p[n-1:0] = a;
      b_p[n-1:0] = b;
   end

   assign g = a_p & b_p;
   assign p = a_p ^ b_p;

   always_comb begin : lookahead
      logic ci;
      logic c1;
      logic c2;
      logic c3;
      logic gg;
      logic pg;
      s_p = '0;
      ci  = cin;
      c1  = 1'b0;
      c2  = 1'b0;
      c3  = 1'b0;
      gg  = 1'b0;
      pg  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         c1 = g[4*k] | (p[4*k] & ci);
         c2 = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & ci);
         c3 = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
            | (p[4*k+2] & p[4*k+1] & p[4*k] & ci);
         gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         s_p[4*k +: 4] = p[4*k +: 4] ^ {c3, c2, c1, ci};
         ci = gg | (pg & ci);
      end
   end

   assign sum        = s_p[n-1:0];
   assign cout       = s_p[n];
   assign unused_pad = ^s_p;

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - sums a programmed number of products into a wide accumulator
// with optional saturation and a sticky overflow flag.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_sat,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod_data,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_data,
   output logic              acc_ovf,
   output logic              busy
);

   state_t             state;
   state_t             state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [LEN_W-1:0]   cnt;
   logic [LEN_W-1:0]   len;
   logic               sat;
   logic               ovf;
   logic               valid_q;
   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   sum;
   logic               carry;
   logic               last;

   always_comb begin
      prod_ext               = '0;
      prod_ext[PROD_W-1:0]   = prod_data;
   end

   cla_nbit #(.n(ACC_W)) u_add (
      .a    (acc),
      .b    (prod_ext),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

   assign last = (cnt == len - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // prod_ready is decoded from state alone so it never depends on prod_valid.
   always_comb begin
      state_nxt  = state;
      prod_ready = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (cfg_len != '0) ? ST_ACC : ST_DONE;
         end
         ST_ACC: begin
            prod_ready = 1'b1;
            if (prod_valid && last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (acc_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         len     <= '0;
         sat     <= 1'b0;
         ovf     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc <= '0;
                  cnt <= '0;
                  ovf <= 1'b0;
                  len <= cfg_len;
                  sat <= cfg_sat;
               end
            end
            ST_ACC: begin
               if (prod_valid) begin
                  cnt <= cnt + 1'b1;
                  if (carry) ovf <= 1'b1;
                  // Once saturated, the accumulator is pinned at all ones for the rest of the run.
                  if (sat && (carry || ovf)) acc <= '1;
                  else                       acc <= sum;
               end
            end
            default: ;
         endcase
      end
   end

   assign acc_valid = valid_q;
   assign acc_data  = acc;
   assign acc_ovf   = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench; drives a 40-bit and a 33-bit accumulator in lockstep.
module tb_mac_accumulator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_len;
   logic        cfg_sat;
   logic        prod_valid;
   logic [31:0] prod_data;
   logic        acc_ready;

   logic        pr40, av40, ao40, bz40;
   logic [39:0] ad40;
   logic        pr33, av33, ao33, bz33;
   logic [32:0] ad33;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [39:0] e40;
      logic        o40;
      logic [39:0] e33;
      logic        o33;
   } exp_t;

   typedef struct {
      int             len;
      bit             sat;
      logic [3:0]     mask;
      logic [3:0][31:0] p;
      logic [39:0]    e40;
      logic           o40;
      logic [39:0]    e33;
      logic           o33;
   } vec_t;

   exp_t        sb[$];
   vec_t        vec[8];
   logic [31:0] cur_p[4];

   mac_accumulator u_dut40 (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_sat(cfg_sat),
      .prod_valid(prod_valid), .prod_ready(pr40), .prod_data(prod_data),
      .acc_valid(av40), .acc_ready(acc_ready), .acc_data(ad40), .acc_ovf(ao40), .busy(bz40)
   );

   mac_accumulator #(.ACC_W(33)) u_dut33 (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_sat(cfg_sat),
      .prod_valid(prod_valid), .prod_ready(pr33), .prod_data(prod_data),
      .acc_valid(av33), .acc_ready(acc_ready), .acc_data(ad33), .acc_ovf(ao33), .busy(bz33)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Results are scored whenever the DUT presents one that is about to be accepted.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && av40 && acc_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: result 0x%0h with nothing expected", ad40);
         end else begin
            e = sb.pop_front();
            check("data40", {24'b0, ad40}, {24'b0, e.e40});
            check("ovf40", {63'b0, ao40}, {63'b0, e.o40});
            check("data33", {31'b0, ad33}, {24'b0, e.e33});
            check("ovf33", {63'b0, ao33}, {63'b0, e.o33});
         end
      end
   end

   task automatic push_exp(input logic [39:0] e40, input logic o40, input logic [39:0] e33, input logic o33);
      exp_t e;
      e.e40 = e40; e.o40 = o40; e.e33 = e33; e.o33 = o33;
      sb.push_back(e);
   endtask

   task automatic do_start(input int len, input bit sat);
      cfg_len = len[7:0];
      cfg_sat = sat;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic send(input int len, input logic [3:0] mask);
      for (int k = 0; k < len; k++) begin
         if (k < 4 && mask[k]) begin
            prod_valid = 1'b0;
            @(posedge clk); #1;
         end
         prod_valid = 1'b1;
         prod_data  = (k < 4) ? cur_p[k] : cur_p[3];
         @(negedge clk);
         check("prod_ready40", {63'b0, pr40}, 64'd1);
         check("prod_ready33", {63'b0, pr33}, 64'd1);
         @(posedge clk); #1;
      end
      prod_valid = 1'b0;
   endtask

   task automatic done_entry();
      @(negedge clk);
      check("latency_valid40", {63'b0, av40}, 64'd1);
      check("latency_valid33", {63'b0, av33}, 64'd1);
      check("done_prod_ready40", {63'b0, pr40}, 64'd0);
      check("done_prod_ready33", {63'b0, pr33}, 64'd0);
   endtask

   task automatic finish_run();
      int n = 0;
      while ((bz40 || av40) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("finish_bound", {63'b0, (n < 20)}, 64'd1);
   endtask

   task automatic set_vec(input int i, input int len, input bit sat, input logic [3:0] mask,
                          input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] p3, input logic [39:0] e40, input logic o40,
                          input logic [39:0] e33, input logic o33);
      vec[i].len = len; vec[i].sat = sat; vec[i].mask = mask;
      vec[i].p[0] = p0; vec[i].p[1] = p1; vec[i].p[2] = p2; vec[i].p[3] = p3;
      vec[i].e40 = e40; vec[i].o40 = o40; vec[i].e33 = e33; vec[i].o33 = o33;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_prod_ready"}, {62'b0, pr40, pr33}, 64'd0);
      check({tag, "_acc_valid"}, {62'b0, av40, av33}, 64'd0);
      check({tag, "_busy"}, {62'b0, bz40, bz33}, 64'd0);
      check({tag, "_ovf"}, {62'b0, ao40, ao33}, 64'd0);
      check({tag, "_data40"}, {24'b0, ad40}, 64'd0);
      check({tag, "_data33"}, {31'b0, ad33}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_sat = 1'b0;
      prod_valid = 1'b0; prod_data = '0; acc_ready = 1'b1;

      set_vec(0, 3,   0, 4'b0000, 32'hFFFE0001, 32'h1, 32'h2, 32'h0,
              40'h00FFFE0004, 0, 40'h00FFFE0004, 0);
      set_vec(1, 0,   0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 40'h0, 0, 40'h0, 0);
      set_vec(2, 3,   0, 4'b0000, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h0,
              40'h02FFFA0003, 0, 40'h00FFFA0003, 1);
      set_vec(3, 3,   1, 4'b0000, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h0,
              40'h02FFFA0003, 0, 40'h01FFFFFFFF, 1);
      set_vec(4, 1,   0, 4'b0000, 32'h5, 32'h0, 32'h0, 32'h0, 40'h5, 0, 40'h5, 0);
      set_vec(5, 255, 0, 4'b0000, 32'h1, 32'h1, 32'h1, 32'h1, 40'd255, 0, 40'd255, 0);
      set_vec(6, 4,   0, 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1,
              40'h0200000000, 0, 40'h0, 1);
      set_vec(7, 6,   1, 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h0,
              40'h0200000000, 0, 40'h01FFFFFFFF, 1);

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) cur_p[k] = vec[i].p[k];
         push_exp(vec[i].e40, vec[i].o40, vec[i].e33, vec[i].o33);
         do_start(vec[i].len, vec[i].sat);
         send(vec[i].len, vec[i].mask);
         done_entry();
         finish_run();
      end

      // Bubbles, then backpressure with an ignored start during the hold.
      cur_p[0] = 32'd10; cur_p[1] = 32'd20; cur_p[2] = 32'd30; cur_p[3] = 32'd40;
      acc_ready = 1'b0;
      push_exp(40'd100, 0, 40'd100, 0);
      do_start(4, 0);
      send(4, 4'b0110);
      done_entry();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         start   = (c == 2);
         cfg_len = 8'd1;
         @(negedge clk);
         check("hold_valid", {62'b0, av40, av33}, 64'd3);
         check("hold_data", {24'b0, ad40}, 64'd100);
         check("hold_prod_ready", {62'b0, pr40, pr33}, 64'd0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      acc_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("release_valid", {62'b0, av40, av33}, 64'd0);
      check("release_busy", {62'b0, bz40, bz33}, 64'd0);
      check("release_data_kept", {24'b0, ad40}, 64'd100);

      // Reset in the middle of an accumulation discards the partial sum.
      cur_p[0] = 32'd11; cur_p[1] = 32'd12; cur_p[2] = 32'd13; cur_p[3] = 32'd14;
      @(posedge clk); #1;
      do_start(5, 0);
      send(2, 4'b0000);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cur_p[0] = 32'd7;
      push_exp(40'd7, 0, 40'd7, 0);
      do_start(1, 0);
      send(1, 4'b0000);
      done_entry();
      finish_run();

      // Start raised in the DONE handshake cycle is ignored; the next cycle's start is taken.
      cur_p[0] = 32'd3;
      push_exp(40'd3, 0, 40'd3, 0);
      do_start(1, 0);
      send(1, 4'b0000);
      start   = 1'b1;
      cfg_len = 8'd1;
      done_entry();
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("done_start_busy", {62'b0, bz40, bz33}, 64'd0);
      check("done_start_valid", {62'b0, av40, av33}, 64'd0);
      @(posedge clk); #1;
      cur_p[0] = 32'd9;
      push_exp(40'd9, 0, 40'd9, 0);
      do_start(1, 0);
      send(1, 4'b0000);
      done_entry();
      finish_run();

      repeat (2) @(posedge clk);
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
